// File: rtl/plane_mover.sv
// plane_mover
//   Turns move codes from the keyboard controls (0 = down, 1 = up, 2/3 = none)
//   into a STEP-pixel vertical glide of the plane. The plane moves one pixel per
//   frame tick and is clamped to [Y_MIN, Y_MAX]. While a glide is in progress,
//   one further command can be queued, and the most recent one wins.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous-assert, active-low reset (release synchronised)
//   move       in   [1:0] move code: 0 = down, 1 = up, 2/3 = no-op
//   frame_tick in   one-clk pulse per video frame
//   plane_y    out  [W-1:0] current plane Y (registered)
//   busy       out  high while gliding up or down
//   at_top     out  plane_y == Y_MIN
//   at_bottom  out  plane_y == Y_MAX
module plane_mover #(
  parameter int unsigned W      = 10,
  parameter int unsigned Y_MIN  = 0,
  parameter int unsigned Y_MAX  = 440,
  parameter int unsigned Y_INIT = 240,
  parameter int unsigned STEP   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   move,
  input  logic         frame_tick,
  output logic [W-1:0] plane_y,
  output logic         busy,
  output logic         at_top,
  output logic         at_bottom
);

  localparam logic [W-1:0] YMIN_C  = W'(Y_MIN);
  localparam logic [W-1:0] YMAX_C  = W'(Y_MAX);
  localparam logic [W-1:0] YINIT_C = W'(Y_INIT);
  localparam logic [W-1:0] STEP_C  = W'(STEP);
  localparam logic [W-1:0] ONE_C   = W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           pend_v_q, pend_v_d;
  logic           pend_up_q, pend_up_d;
  logic           rst_ok_q;

  logic           cmd_valid;
  logic           cmd_up;
  logic           move_valid;

  assign move_valid = (move == 2'd0) || (move == 2'd1);

  // Reset release is aligned to clk: the datapath is held in its reset values
  // for the first edge after release and samples commands from the second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_ok_q <= 1'b0;
    end else begin
      rst_ok_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    rem_d     = rem_q;
    pend_v_d  = pend_v_q;
    pend_up_d = pend_up_q;
    cmd_valid = 1'b0;
    cmd_up    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A queued command takes priority; a live move in the same cycle is lost.
        if (pend_v_q) begin
          cmd_valid = 1'b1;
          cmd_up    = pend_up_q;
          pend_v_d  = 1'b0;
        end else if (move_valid) begin
          cmd_valid = 1'b1;
          cmd_up    = move[0];
        end

        if (cmd_valid) begin
          if (cmd_up && (y_q > YMIN_C)) begin
            state_d = MOVE_UP;
            rem_d   = STEP_C;
          end else if (!cmd_up && (y_q < YMAX_C)) begin
            state_d = MOVE_DOWN;
            rem_d   = STEP_C;
          end
        end
      end

      MOVE_UP: begin
        if (move_valid) begin
          pend_v_d  = 1'b1;
          pend_up_d = move[0];
        end
        if (frame_tick) begin
          // Bound checked before decrementing so Y_MIN = 0 cannot underflow.
          if (y_q == YMIN_C) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            y_d   = y_q - ONE_C;
            rem_d = rem_q - ONE_C;
            if ((rem_q == ONE_C) || (y_q == YMIN_C + ONE_C)) begin
              state_d = IDLE;
              rem_d   = '0;
            end
          end
        end
      end

      MOVE_DOWN: begin
        if (move_valid) begin
          pend_v_d  = 1'b1;
          pend_up_d = move[0];
        end
        if (frame_tick) begin
          if (y_q == YMAX_C) begin
            state_d = IDLE;
            rem_d   = '0;
          end else begin
            y_d   = y_q + ONE_C;
            rem_d = rem_q - ONE_C;
            if ((rem_q == ONE_C) || (y_q == YMAX_C - ONE_C)) begin
              state_d = IDLE;
              rem_d   = '0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
        rem_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= YINIT_C;
      rem_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_up_q <= 1'b0;
    end else if (!rst_ok_q) begin
      state_q   <= IDLE;
      y_q       <= YINIT_C;
      rem_q     <= '0;
      pend_v_q  <= 1'b0;
      pend_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      rem_q     <= rem_d;
      pend_v_q  <= pend_v_d;
      pend_up_q <= pend_up_d;
    end
  end

  assign plane_y   = y_q;
  assign busy      = (state_q != IDLE);
  assign at_top    = (y_q == YMIN_C);
  assign at_bottom = (y_q == YMAX_C);

endmodule

// File: tb/tb_plane_mover.sv
module tb_plane_mover;

  logic       clk;
  logic       rst_n;
  logic [1:0] move;
  logic       frame_tick;
  logic [9:0] plane_y;
  logic       busy;
  logic       at_top;
  logic       at_bottom;

  int checks;
  int errors;

  plane_mover #(
    .W     (10),
    .Y_MIN (0),
    .Y_MAX (440),
    .Y_INIT(240),
    .STEP  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .move      (move),
    .frame_tick(frame_tick),
    .plane_y   (plane_y),
    .busy      (busy),
    .at_top    (at_top),
    .at_bottom (at_bottom)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic [1:0] m, input logic t);
    move       = m;
    frame_tick = t;
    @(posedge clk);
    #1;
    move       = 2'd2;
    frame_tick = 1'b0;
  endtask

  task automatic glide(input logic [1:0] dir);
    cyc(dir, 1'b0);
    repeat (16) cyc(2'd2, 1'b1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y", int'(plane_y), 240);
    chk("rst_busy", int'(busy), 0);
    #1 rst_n = 1'b1;
    cyc(2'd2, 1'b0);
    cyc(2'd2, 1'b0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    move       = 2'd2;
    frame_tick = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("init_y", int'(plane_y), 240);
    chk("init_busy", int'(busy), 0);
    chk("init_top", int'(at_top), 0);
    chk("init_bot", int'(at_bottom), 0);

    // Command on the first edge after release is dropped.
    #2 rst_n = 1'b1;
    cyc(2'd1, 1'b0);
    chk("release_1st_edge_busy", int'(busy), 0);
    cyc(2'd2, 1'b0);
    chk("release_2nd_edge_busy", int'(busy), 0);
    chk("release_y", int'(plane_y), 240);

    // Up glide 240 -> 224
    cyc(2'd1, 1'b0);
    chk("up_accept_busy", int'(busy), 1);
    chk("up_accept_y", int'(plane_y), 240);
    for (int i = 1; i <= 16; i++) begin
      cyc(2'd2, 1'b1);
      chk("up_step_y", int'(plane_y), 240 - i);
      chk("up_step_busy", int'(busy), (i < 16) ? 1 : 0);
    end

    // Async reset mid-glide, no clock edge
    cyc(2'd0, 1'b0);
    cyc(2'd2, 1'b1);
    chk("mid_y", int'(plane_y), 225);
    chk("mid_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_y", int'(plane_y), 240);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_top", int'(at_top), 0);
    chk("async_rst_bot", int'(at_bottom), 0);
    #1 rst_n = 1'b1;
    cyc(2'd2, 1'b0);
    cyc(2'd2, 1'b0);

    // Walk down to 432, then clamp at 440
    repeat (12) glide(2'd0);
    chk("pre_clamp_y", int'(plane_y), 432);
    chk("pre_clamp_busy", int'(busy), 0);
    cyc(2'd0, 1'b0);
    chk("clamp_accept_busy", int'(busy), 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(2'd2, 1'b1);
      chk("clamp_step_y", int'(plane_y), 432 + i);
    end
    chk("clamp_busy", int'(busy), 0);
    chk("clamp_bot", int'(at_bottom), 1);
    repeat (8) cyc(2'd2, 1'b1);
    chk("clamp_hold_y", int'(plane_y), 440);

    // Blocked down at bottom, then up accepted
    cyc(2'd0, 1'b0);
    chk("blocked_busy", int'(busy), 0);
    chk("blocked_y", int'(plane_y), 440);
    cyc(2'd2, 1'b0);
    chk("blocked_busy2", int'(busy), 0);
    cyc(2'd1, 1'b0);
    chk("unblock_busy", int'(busy), 1);
    repeat (16) cyc(2'd2, 1'b1);
    chk("unblock_y", int'(plane_y), 424);
    chk("unblock_busy_end", int'(busy), 0);
    chk("unblock_bot", int'(at_bottom), 0);

    // Queue: last command wins
    do_reset();
    cyc(2'd1, 1'b0);
    repeat (4) cyc(2'd2, 1'b1);
    chk("q_mid_y", int'(plane_y), 236);
    cyc(2'd0, 1'b0);
    cyc(2'd2, 1'b1);
    cyc(2'd1, 1'b0);
    repeat (11) cyc(2'd2, 1'b1);
    chk("q_first_end_y", int'(plane_y), 224);
    chk("q_first_end_busy", int'(busy), 0);
    cyc(2'd2, 1'b0);
    chk("q_second_busy", int'(busy), 1);
    chk("q_second_start_y", int'(plane_y), 224);
    repeat (16) cyc(2'd2, 1'b1);
    chk("q_second_end_y", int'(plane_y), 208);
    chk("q_second_end_busy", int'(busy), 0);
    repeat (3) cyc(2'd2, 1'b0);
    chk("q_no_third_busy", int'(busy), 0);
    repeat (16) cyc(2'd2, 1'b1);
    chk("q_no_third_y", int'(plane_y), 208);

    // No-op codes and idle ticks
    do_reset();
    for (int i = 0; i < 50; i++) begin
      cyc((i % 2 == 0) ? 2'd2 : 2'd3, 1'b1);
    end
    chk("noop_y", int'(plane_y), 240);
    chk("noop_busy", int'(busy), 0);
    chk("noop_top", int'(at_top), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
